// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, branch func3 codes and
// the PC sequencer state type.
package riscv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } pcseq_state_t;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: signed/unsigned compares selected by func3.
// Reserved func3 codes (010/011) yield a false condition.
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1v,
    input  logic [XLEN-1:0] rs2v,
    output logic            cond
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1v == rs2v);
    assign lt_s = ($signed(rs1v) < $signed(rs2v));
    assign lt_u = (rs1v < rs2v);

    always_comb begin
        cond = 1'b0;
        case (func3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = !lt_s;
            F3_BLTU: cond = lt_u;
            F3_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multi-cycle core: resolves control
// transfers, traps on misaligned targets and counts taken transfers.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_update,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  rs1v,
    input  logic [XLEN-1:0]  rs2v,
    input  logic [XLEN-1:0]  target,
    input  logic             trap_ack,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             taken,
    output logic             trap_pending,
    output logic [XLEN-1:0]  fault_pc,
    output logic [XLEN-1:0]  fault_target,
    output logic [CNT_W-1:0] taken_count
);

    generate
        if (IALIGN != 2 && IALIGN != 4) begin : g_bad_ialign
            $error("pc_sequencer: IALIGN must be 2 or 4");
        end
    endgenerate

    pcseq_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  fpc_q, fpc_d;
    logic [XLEN-1:0]  ftgt_q, ftgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cond;
    logic [XLEN-1:0]  eff_tgt;
    logic             misaligned;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .func3 (func3),
        .rs1v  (rs1v),
        .rs2v  (rs2v),
        .cond  (cond)
    );

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BRANCH:      taken = cond;
            OP_JAL,
            OP_JALR:        taken = 1'b1;
            default:        taken = 1'b0;
        endcase
    end

    // JALR clears bit 0 of the computed target before use.
    assign eff_tgt = (opcode == OP_JALR) ?
                     {target[XLEN-1:1], 1'b0} : target;

    always_comb begin
        misaligned = 1'b0;
        if (taken) begin
            if (IALIGN == 4) begin
                misaligned = (eff_tgt[1:0] != 2'b00);
            end else begin
                misaligned = eff_tgt[0];
            end
        end
    end

    assign pc_plus_inc = pc_q + XLEN'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fpc_d   = fpc_q;
        ftgt_d  = ftgt_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (pc_update) begin
                    if (!taken) begin
                        pc_d = pc_plus_inc;
                    end else if (misaligned) begin
                        pc_d    = TRAP_VECTOR;
                        fpc_d   = pc_q;
                        ftgt_d  = eff_tgt;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d  = eff_tgt;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_TRAP: begin
                // PC is frozen until the controller acknowledges.
                if (trap_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            fpc_q   <= '0;
            ftgt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fpc_q   <= fpc_d;
            ftgt_q  <= ftgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign trap_pending = (state_q == ST_TRAP);
    assign fault_pc     = fpc_q;
    assign fault_target = ftgt_q;
    assign taken_count  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two instances (IALIGN=4 with a
// 3-bit counter, IALIGN=2 default) share stimulus.
module tb_pc_sequencer;

    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    logic        clk;
    logic        rst;
    logic        upd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b, t;
    logic        ack;

    logic [31:0] pcA, ppiA, fpcA, ftA;
    logic        tkA, trA;
    logic [2:0]  cntA;
    logic [31:0] pcB, ppiB, fpcB, ftB;
    logic        tkB, trB;
    logic [15:0] cntB;

    pc_sequencer #(
        .IALIGN (4),
        .CNT_W  (3)
    ) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .pc_update    (upd),
        .opcode       (op),
        .func3        (f3),
        .rs1v         (a),
        .rs2v         (b),
        .target       (t),
        .trap_ack     (ack),
        .pc           (pcA),
        .pc_plus_inc  (ppiA),
        .taken        (tkA),
        .trap_pending (trA),
        .fault_pc     (fpcA),
        .fault_target (ftA),
        .taken_count  (cntA)
    );

    pc_sequencer #(
        .IALIGN (2)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .pc_update    (upd),
        .opcode       (op),
        .func3        (f3),
        .rs1v         (a),
        .rs2v         (b),
        .target       (t),
        .trap_ack     (ack),
        .pc           (pcB),
        .pc_plus_inc  (ppiB),
        .taken        (tkB),
        .trap_pending (trB),
        .fault_pc     (fpcB),
        .fault_target (ftB),
        .taken_count  (cntB)
    );

    typedef struct {
        string       nm;
        bit          d;
        bit          cc;
        logic        tk;
        logic [31:0] ppi;
        logic [31:0] pc;
        logic        tr;
        logic [31:0] fpc;
        logic [31:0] ft;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic drv(input bit r, input bit u, input logic [6:0] o,
                       input logic [2:0] f, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [31:0] tg,
                       input bit ak);
        @(negedge clk);
        rst = r;
        upd = u;
        op  = o;
        f3  = f;
        a   = ra;
        b   = rb;
        t   = tg;
        ack = ak;
    endtask

    task automatic ex(input string nm, input bit d, input bit cc,
                      input logic tk, input logic [31:0] ppi,
                      input logic [31:0] pcv, input logic tr,
                      input logic [31:0] fpc, input logic [31:0] ft,
                      input logic [15:0] cnt);
        exp_t e;
        e.nm  = nm;
        e.d   = d;
        e.cc  = cc;
        e.tk  = tk;
        e.ppi = ppi;
        e.pc  = pcv;
        e.tr  = tr;
        e.fpc = fpc;
        e.ft  = ft;
        e.cnt = cnt;
        q.push_back(e);
    endtask

    // Monitor: comb outputs mid-cycle, registered outputs after the edge.
    initial begin
        exp_t cur[$];
        forever begin
            @(negedge clk);
            #2;
            cur.delete();
            while (q.size() > 0) cur.push_back(q.pop_front());
            foreach (cur[i]) begin
                if (cur[i].cc) begin
                    chk({cur[i].nm, ".taken"},
                        32'(cur[i].d ? tkB : tkA), 32'(cur[i].tk));
                    chk({cur[i].nm, ".pc_plus_inc"},
                        cur[i].d ? ppiB : ppiA, cur[i].ppi);
                end
            end
            @(posedge clk);
            #1;
            foreach (cur[i]) begin
                chk({cur[i].nm, ".pc"},
                    cur[i].d ? pcB : pcA, cur[i].pc);
                chk({cur[i].nm, ".trap_pending"},
                    32'(cur[i].d ? trB : trA), 32'(cur[i].tr));
                chk({cur[i].nm, ".fault_pc"},
                    cur[i].d ? fpcB : fpcA, cur[i].fpc);
                chk({cur[i].nm, ".fault_target"},
                    cur[i].d ? ftB : ftA, cur[i].ft);
                chk({cur[i].nm, ".taken_count"},
                    32'(cur[i].d ? cntB : {13'd0, cntA}),
                    32'(cur[i].cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, n_err %0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; upd = 1'b0; op = OPR; f3 = 3'd0;
        a = '0; b = '0; t = '0; ack = 1'b0;

        drv(1, 0, OPR, 0, 0, 0, 0, 0);
        ex("reset_a", 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        ex("reset_b", 1, 0, 0, 0, 32'h0, 0, 0, 0, 0);

        drv(0, 1, OPR, 0, 0, 0, 0, 0);
        ex("seq1", 0, 1, 0, 32'h4, 32'h4, 0, 0, 0, 0);
        drv(0, 1, OPR, 0, 0, 0, 0, 0);
        ex("seq2", 0, 1, 0, 32'h8, 32'h8, 0, 0, 0, 0);
        drv(0, 1, OPR, 0, 0, 0, 0, 0);
        ex("seq3", 0, 1, 0, 32'hC, 32'hC, 0, 0, 0, 0);

        drv(0, 0, BR, 3'b100, 32'hFFFF_FFFF, 1, 32'h40, 0);
        ex("blt_hold", 0, 1, 1, 32'h10, 32'hC, 0, 0, 0, 0);
        drv(0, 1, BR, 3'b100, 32'hFFFF_FFFF, 1, 32'h40, 0);
        ex("blt", 0, 1, 1, 32'h10, 32'h40, 0, 0, 0, 1);
        drv(0, 1, BR, 3'b110, 32'hFFFF_FFFF, 1, 32'h40, 0);
        ex("bltu", 0, 1, 0, 32'h44, 32'h44, 0, 0, 0, 1);

        drv(0, 1, JALR, 0, 0, 0, 32'h81, 0);
        ex("jalr", 0, 1, 1, 32'h48, 32'h80, 0, 0, 0, 2);
        drv(0, 1, BR, 3'b000, 5, 5, 32'h20, 0);
        ex("beq", 0, 1, 1, 32'h84, 32'h20, 0, 0, 0, 3);

        drv(0, 0, BR, 3'b001, 5, 5, 32'h40, 0);
        ex("bne_nt", 0, 1, 0, 32'h24, 32'h20, 0, 0, 0, 3);
        drv(0, 0, BR, 3'b101, 1, 32'hFFFF_FFFF, 32'h40, 0);
        ex("bge_t", 0, 1, 1, 32'h24, 32'h20, 0, 0, 0, 3);
        drv(0, 0, BR, 3'b111, 1, 32'hFFFF_FFFF, 32'h40, 0);
        ex("bgeu_nt", 0, 1, 0, 32'h24, 32'h20, 0, 0, 0, 3);
        drv(0, 0, BR, 3'b010, 5, 5, 32'h40, 0);
        ex("f3_010", 0, 1, 0, 32'h24, 32'h20, 0, 0, 0, 3);
        drv(0, 0, OPI, 3'b000, 5, 5, 32'h40, 0);
        ex("opi", 0, 1, 0, 32'h24, 32'h20, 0, 0, 0, 3);

        drv(0, 1, BR, 3'b000, 7, 7, 32'h102, 0);
        ex("trap_a", 0, 1, 1, 32'h24, 32'h100, 1, 32'h20, 32'h102, 3);
        ex("ialign2_b", 1, 1, 1, 32'h24, 32'h102, 0, 0, 0, 4);

        for (int i = 0; i < 3; i++) begin
            drv(0, 1, OPR, 0, 0, 0, 0, 0);
            ex("trap_hold", 0, 1, 0, 32'h104, 32'h100, 1,
               32'h20, 32'h102, 3);
        end
        drv(0, 1, OPR, 0, 0, 0, 0, 1);
        ex("trap_ack", 0, 1, 0, 32'h104, 32'h100, 0,
           32'h20, 32'h102, 3);
        drv(0, 1, OPR, 0, 0, 0, 0, 0);
        ex("post_trap", 0, 1, 0, 32'h104, 32'h104, 0,
           32'h20, 32'h102, 3);

        drv(0, 1, JAL, 0, 0, 0, 32'h200, 0);
        ex("jal4", 0, 1, 1, 32'h108, 32'h200, 0, 32'h20, 32'h102, 4);
        drv(0, 1, JAL, 0, 0, 0, 32'h300, 0);
        ex("jal5", 0, 1, 1, 32'h204, 32'h300, 0, 32'h20, 32'h102, 5);
        drv(0, 1, JAL, 0, 0, 0, 32'h400, 0);
        ex("jal6", 0, 1, 1, 32'h304, 32'h400, 0, 32'h20, 32'h102, 6);
        drv(0, 1, JAL, 0, 0, 0, 32'h500, 0);
        ex("jal7", 0, 1, 1, 32'h404, 32'h500, 0, 32'h20, 32'h102, 7);
        drv(0, 1, JAL, 0, 0, 0, 32'hFFFF_FFFC, 0);
        ex("cnt_wrap", 0, 1, 1, 32'h504, 32'hFFFF_FFFC, 0,
           32'h20, 32'h102, 0);
        drv(0, 1, OPR, 0, 0, 0, 0, 0);
        ex("pc_wrap", 0, 1, 0, 32'h0, 32'h0, 0, 32'h20, 32'h102, 0);

        drv(0, 1, JAL, 0, 0, 0, 32'h6, 0);
        ex("trap_jal", 0, 1, 1, 32'h4, 32'h100, 1, 32'h0, 32'h6, 0);
        drv(1, 1, JAL, 0, 0, 0, 32'h6, 1);
        ex("rst_in_trap", 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        drv(0, 1, OPR, 0, 0, 0, 0, 0);
        ex("after_rst", 0, 1, 0, 32'h4, 32'h4, 0, 0, 0, 0);
        drv(0, 0, OPR, 0, 0, 0, 0, 1);
        ex("ack_in_run", 0, 1, 0, 32'h8, 32'h4, 0, 0, 0, 0);

        drv(0, 0, OPR, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the multi-cycle RISC-V core, successor to the single-mode PC register. It resolves all control-transfer opcodes (B-type with correct signed/unsigned compare, JAL, JALR) and advances the PC only when the multi-cycle controller strobes `pc_update`. It also detects misaligned targets and redirects to a trap vector under a two-state FSM, and keeps a taken-transfer performance counter.

## Interface
- `XLEN`, 32, datapath and PC width
- `RESET_VECTOR`, 0, PC value after reset
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on misaligned-target trap
- `IALIGN`, 4, instruction alignment in bytes; only 4 or 2 legal
- `CNT_W`, 16, taken-transfer counter width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc_update`  in  1  controller strobe: commit next PC this edge
- `opcode`  in  7  current instruction opcode
- `func3`  in  3  current instruction func3
- `rs1v`, `rs2v`  in  XLEN  register operands for branch compare
- `target`  in  XLEN  ALU-computed transfer target (PC+imm or rs1+imm)
- `trap_ack`  in  1  controller acknowledges trap
- `pc`  out  XLEN  current PC (registered)
- `pc_plus_inc`  out  XLEN  `pc + 4`, combinational link value for JAL/JALR
- `taken`  out  1  combinational: transfer would be taken this cycle
- `trap_pending`  out  1  registered: FSM in TRAP
- `fault_pc`  out  XLEN  registered: PC of faulting instruction
- `fault_target`  out  XLEN  registered: offending target
- `taken_count`  out  CNT_W  registered count of committed taken transfers

## Operation
- Taken decision (combinational, from current inputs, no lag):
  - opcode 1100011: func3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken.
  - opcode 1101111 (JAL): taken.
  - opcode 1100111 (JALR): taken; effective target has bit 0 forced to 0.
  - All other opcodes: not taken.
- Misaligned: taken and effective target mod IALIGN != 0 (IALIGN=4: bits[1:0]; IALIGN=2: bit 0).
- FSM states RUN, TRAP.
  - RUN, `pc_update`=0: hold all state.
  - RUN, `pc_update`=1, not taken: `pc <= pc + 4`.
  - RUN, `pc_update`=1, taken, aligned: `pc <= effective target`; `taken_count` increments.
  - RUN, `pc_update`=1, taken, misaligned: `pc <= TRAP_VECTOR`, `fault_pc <= pc`, `fault_target <= effective target`, go to TRAP; counter unchanged.
  - TRAP: `pc_update` ignored, PC held; `trap_ack`=1 -> RUN.
  - `trap_ack` in RUN is ignored.
- Arithmetic: PC increment wraps modulo 2^XLEN; `taken_count` wraps to 0 at all-ones.
- Signed compares use `$signed` on full XLEN operands.

## Timing
- Reset (`rst`=1 at edge, dominates all inputs): `pc`=RESET_VECTOR, state RUN, `trap_pending`=0, `fault_pc`=0, `fault_target`=0, `taken_count`=0.
- Reset mid-TRAP returns to RUN at RESET_VECTOR and clears the fault registers.
- Decision-to-PC latency: 1 edge. The inputs sampled at the `pc_update` edge determine the new `pc`.
- `taken` and `pc_plus_inc` are valid in the same cycle as their inputs.
- `trap_pending` rises on the edge after the faulting `pc_update` and falls on the edge after `trap_ack`.
- The first `pc_update` honoured after a trap is in the cycle following the falling edge of `trap_pending`.
- `pc_update` and `trap_ack` both high in TRAP: exit to RUN only; PC does not advance.

## Structure
- Shared package `riscv_pkg`: opcode constants (OP_BRANCH, OP_JAL, OP_JALR), func3 branch constants, `pcseq_state_t` enum.
- One sub-module `branch_cmp`, combinational (func3, rs1v, rs2v -> cond); the top holds the FSM, PC, fault and counter registers.
- Elaboration-time assertion that IALIGN is 2 or 4.

## Test plan
- Reset, then 3 `pc_update` strobes with opcode 0110011 -> `pc` = 0, 4, 8, 12; `taken_count` = 0.
- BLT, rs1v=32'hFFFF_FFFF, rs2v=1, target=0x40 -> taken, `pc`=0x40. Same operands with BLTU -> not taken, `pc` = old + 4.
- JALR, target=0x81, IALIGN=4 -> effective target 0x80, `pc`=0x80, `taken_count` +1, `pc_plus_inc` = old pc + 4 during the cycle.
- BEQ taken, target=0x102, `pc`=0x20 -> `pc`=0x100, `trap_pending`=1, `fault_pc`=0x20, `fault_target`=0x102. `pc_update` held 3 cycles leaves `pc` unchanged. `trap_ack` -> RUN. Repeat with IALIGN=2 -> no trap, `pc`=0x102.
- `pc`=32'hFFFF_FFFC, not-taken `pc_update` -> `pc`=0. `taken_count` preloaded at all-ones plus one taken JAL -> 0.
- `rst` asserted while in TRAP, with `pc_update` and `trap_ack` also high -> next cycle `pc`=RESET_VECTOR, `trap_pending`=0, `fault_pc`=0.
